// File: rtl/acq_burst_seq.sv
// Acquisition sequencer: a synchronised start edge launches NBURST bursts of DLEN
// FIFO-gated beats, with an initial DELAY and GAP idle cycles between bursts.
module acq_burst_seq #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned NB_W     = 8,
    parameter int unsigned SYNC_LEN = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ASYNC_START,
    input  logic             ABORT,
    input  logic             FIFO_VALID,
    input  logic [CNT_W-1:0] DLEN,
    input  logic [CNT_W-1:0] DELAY,
    input  logic [CNT_W-1:0] GAP,
    input  logic [NB_W-1:0]  NBURST,
    output logic             SYNC_READY,
    output logic             OUT_VALID,
    output logic             DONE,
    output logic             BUSY,
    output logic [NB_W-1:0]  BURST_IDX,
    output logic             ERR
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_DLY  = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    logic [SYNC_LEN-1:0] sync_q;
    logic                sync_d;
    logic                start_edge;

    logic [CNT_W-1:0] dlen_q1, dlen_q2, delay_q1, delay_q2, gap_q1, gap_q2;
    logic [NB_W-1:0]  nburst_q1, nburst_q2;
    logic [CNT_W-1:0] dlen_s, delay_s, gap_s;
    logic [NB_W-1:0]  nburst_s;

    logic [2:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] beat, beat_nx;
    logic [NB_W-1:0]  idx, idx_nx;
    logic             sync_ready, sync_ready_nx;
    logic             done, done_nx;
    logic             busy, busy_nx;
    logic             err, err_nx;
    logic             cfg_ld;
    logic             abort_act;

    // Chain resets to all-ones so a start level held across reset release is not an edge
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= '1;
            sync_d <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_LEN-2:0], ASYNC_START};
            sync_d <= sync_q[SYNC_LEN-1];
        end
    end

    assign start_edge = sync_q[SYNC_LEN-1] & ~sync_d;

    // Two-stage registration of quasi-static config, then shadow capture on accepted start
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dlen_q1   <= '0;
            dlen_q2   <= '0;
            delay_q1  <= '0;
            delay_q2  <= '0;
            gap_q1    <= '0;
            gap_q2    <= '0;
            nburst_q1 <= '0;
            nburst_q2 <= '0;
            dlen_s    <= '0;
            delay_s   <= '0;
            gap_s     <= '0;
            nburst_s  <= '0;
        end else begin
            dlen_q1   <= DLEN;
            dlen_q2   <= dlen_q1;
            delay_q1  <= DELAY;
            delay_q2  <= delay_q1;
            gap_q1    <= GAP;
            gap_q2    <= gap_q1;
            nburst_q1 <= NBURST;
            nburst_q2 <= nburst_q1;
            if (cfg_ld) begin
                dlen_s   <= dlen_q2;
                delay_s  <= delay_q2;
                gap_s    <= gap_q2;
                nburst_s <= nburst_q2;
            end
        end
    end

    assign abort_act = ABORT & ((state == S_ARM) | (state == S_DLY) |
                                (state == S_RUN) | (state == S_GAP));
    assign OUT_VALID = (state == S_RUN) & FIFO_VALID & ~ABORT;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            cnt        <= '0;
            beat       <= '0;
            idx        <= '0;
            sync_ready <= 1'b0;
            done       <= 1'b1;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            beat       <= beat_nx;
            idx        <= idx_nx;
            sync_ready <= sync_ready_nx;
            done       <= done_nx;
            busy       <= busy_nx;
            err        <= err_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        beat_nx       = beat;
        idx_nx        = idx;
        sync_ready_nx = sync_ready;
        done_nx       = done;
        busy_nx       = busy;
        err_nx        = err;
        cfg_ld        = 1'b0;

        if (abort_act) begin
            state_nx = S_FIN;
            cnt_nx   = '0;
            beat_nx  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        if ((dlen_q2 == '0) || (nburst_q2 == '0)) begin
                            err_nx = 1'b1;
                        end else begin
                            err_nx        = 1'b0;
                            done_nx       = 1'b0;
                            busy_nx       = 1'b1;
                            sync_ready_nx = 1'b1;
                            idx_nx        = '0;
                            cnt_nx        = '0;
                            beat_nx       = '0;
                            cfg_ld        = 1'b1;
                            state_nx      = S_ARM;
                        end
                    end
                end
                S_ARM: begin
                    if (FIFO_VALID) begin
                        cnt_nx   = '0;
                        beat_nx  = '0;
                        state_nx = (delay_s == '0) ? S_RUN : S_DLY;
                    end
                end
                S_DLY: begin
                    if (cnt == delay_s - CNT_W'(1)) begin
                        cnt_nx   = '0;
                        state_nx = S_RUN;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (OUT_VALID) begin
                        if (beat == dlen_s - CNT_W'(1)) begin
                            beat_nx = '0;
                            if (idx == nburst_s - NB_W'(1)) begin
                                state_nx = S_FIN;
                            end else begin
                                idx_nx = idx + NB_W'(1);
                                if (gap_s != '0) begin
                                    cnt_nx        = '0;
                                    sync_ready_nx = 1'b0;
                                    state_nx      = S_GAP;
                                end
                            end
                        end else begin
                            beat_nx = beat + CNT_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (cnt == gap_s - CNT_W'(1)) begin
                        cnt_nx        = '0;
                        sync_ready_nx = 1'b1;
                        state_nx      = S_RUN;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                S_FIN: begin
                    sync_ready_nx = 1'b0;
                    busy_nx       = 1'b0;
                    done_nx       = 1'b1;
                    cnt_nx        = '0;
                    beat_nx       = '0;
                    state_nx      = S_IDLE;
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
    end

    assign SYNC_READY = sync_ready;
    assign DONE       = done;
    assign BUSY       = busy;
    assign BURST_IDX  = idx;
    assign ERR        = err;

endmodule

// File: tb/tb_acq_burst_seq.sv
// Scoreboard bench for acq_burst_seq: expected beats (cycle, burst index) are
// queued at each start and checked by a monitor on every OUT_VALID.
module tb_acq_burst_seq;

    localparam int unsigned CNT_W    = 32;
    localparam int unsigned NB_W     = 8;
    localparam int unsigned SYNC_LEN = 2;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             ASYNC_START = 1'b0;
    logic             ABORT = 1'b0;
    logic             FIFO_VALID = 1'b0;
    logic [CNT_W-1:0] DLEN = '0;
    logic [CNT_W-1:0] DELAY = '0;
    logic [CNT_W-1:0] GAP = '0;
    logic [NB_W-1:0]  NBURST = '0;
    logic             SYNC_READY, OUT_VALID, DONE, BUSY, ERR;
    logic [NB_W-1:0]  BURST_IDX;

    acq_burst_seq #(.CNT_W(CNT_W), .NB_W(NB_W), .SYNC_LEN(SYNC_LEN)) dut (
        .CLK(CLK), .RST_N(RST_N), .ASYNC_START(ASYNC_START), .ABORT(ABORT),
        .FIFO_VALID(FIFO_VALID), .DLEN(DLEN), .DELAY(DELAY), .GAP(GAP),
        .NBURST(NBURST), .SYNC_READY(SYNC_READY), .OUT_VALID(OUT_VALID),
        .DONE(DONE), .BUSY(BUSY), .BURST_IDX(BURST_IDX), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int idx;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   failures = 0;
    bit   fv_rnd = 1'b0;
    int   stall_lo = -1;
    int   stall_hi = -1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FIFO_VALID source: random, or high except inside a forced stall window
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            FIFO_VALID = fv_rnd ? ($urandom_range(0, 3) != 0)
                                : !(cyc >= stall_lo && cyc <= stall_hi);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST_N && OUT_VALID) begin
                if (expq.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("beat_idx", BURST_IDX, e.idx);
                    if (e.cyc >= 0) chk("beat_cycle", cyc, e.cyc);
                    chk("beat_busy", BUSY, 1);
                    chk("beat_ready", SYNC_READY, 1);
                end
            end
        end
    end

    task automatic wait_neg(input int n);
        do @(negedge CLK); while (cyc < n);
    endtask

    task automatic set_cfg(input int dl, input int de, input int ga, input int nb);
        DLEN   = CNT_W'(dl);
        DELAY  = CNT_W'(de);
        GAP    = CNT_W'(ga);
        NBURST = NB_W'(nb);
        repeat (3) @(negedge CLK);
    endtask

    // Raise start, check SYNC_READY rises exactly SYNC_LEN+1 edges later
    task automatic do_start(input bit ok, output int c0);
        @(posedge CLK);
        #1;
        ASYNC_START = 1'b1;
        c0 = cyc;
        wait_neg(c0 + SYNC_LEN);
        chk("ready_early", SYNC_READY, 0);
        wait_neg(c0 + SYNC_LEN + 1);
        chk("ready_rise", SYNC_READY, ok);
        chk("busy_start", BUSY, ok);
        chk("done_start", DONE, !ok);
        chk("err_start", ERR, !ok);
        ASYNC_START = 1'b0;
    endtask

    // Beats occur on FIFO-valid cycles of each burst window; GAP idle cycles between bursts
    task automatic sched(input int first, input int dl, input int nb, input int ga,
                         input bit timed, input int limit, output int last);
        int t;
        int n;
        exp_t e;
        t = first;
        n = 0;
        last = -1;
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < dl; k++) begin
                while (t >= stall_lo && t <= stall_hi) t++;
                if (n < limit) begin
                    e.cyc = timed ? t : -1;
                    e.idx = b;
                    expq.push_back(e);
                end
                last = t;
                n++;
                t++;
            end
            t += ga;
        end
    endtask

    task automatic wait_done(input int exp_done);
        int k;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!DONE && k < 3000);
        if (!DONE) chk("done_timeout", 0, 1);
        else if (exp_done >= 0) chk("done_cycle", cyc, exp_done);
        chk("left_beats", expq.size(), 0);
        chk("busy_end", BUSY, 0);
        chk("ready_end", SYNC_READY, 0);
        chk("err_end", ERR, 0);
        expq.delete();
        repeat (3) @(negedge CLK);
    endtask

    task automatic run_valid(input int dl, input int de, input int ga, input int nb,
                             input bit rnd, input int st_off, input int st_len);
        int c0;
        int first;
        int last;
        set_cfg(dl, de, ga, nb);
        fv_rnd = rnd;
        do_start(1'b1, c0);
        first = c0 + SYNC_LEN + 2 + de;
        if (st_len > 0) begin
            stall_lo = first + st_off;
            stall_hi = first + st_off + st_len - 1;
        end
        sched(first, dl, nb, ga, !rnd, 1 << 30, last);
        // Config changes mid-sequence must not affect the running sequence
        DLEN   = CNT_W'($urandom_range(0, 9));
        NBURST = NB_W'($urandom_range(0, 5));
        GAP    = CNT_W'($urandom_range(0, 5));
        DELAY  = CNT_W'($urandom_range(0, 5));
        wait_done(rnd ? -1 : last + 2);
        stall_lo = -1;
        stall_hi = -1;
        fv_rnd = 1'b0;
    endtask

    task automatic run_err(input int dl, input int nb);
        int c0;
        set_cfg(dl, 2, 1, nb);
        do_start(1'b0, c0);
        repeat (6) @(negedge CLK);
        chk("err_hold", ERR, 1);
        chk("err_done", DONE, 1);
        chk("err_busy", BUSY, 0);
        repeat (2) @(negedge CLK);
    endtask

    task automatic run_abort();
        int c0;
        int first;
        int last;
        set_cfg(4, 0, 1, 3);
        do_start(1'b1, c0);
        first = c0 + SYNC_LEN + 2;
        sched(first, 4, 3, 1, 1'b1, 5, last);
        wait_neg(first + 5);
        @(posedge CLK);
        #1;
        ABORT = 1'b1;
        wait_neg(first + 6);
        chk("abort_out_valid", OUT_VALID, 0);
        @(posedge CLK);
        #1;
        ABORT = 1'b0;
        wait_neg(first + 7);
        chk("abort_done_early", DONE, 0);
        wait_neg(first + 8);
        chk("abort_done", DONE, 1);
        chk("abort_busy", BUSY, 0);
        chk("abort_idx_hold", BURST_IDX, 1);
        chk("abort_left_beats", expq.size(), 0);
        expq.delete();
        repeat (3) @(negedge CLK);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, SYNC_READY, 0);
        chk({tag, "_out_valid"}, OUT_VALID, 0);
        chk({tag, "_done"}, DONE, 1);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_idx"}, BURST_IDX, 0);
        chk({tag, "_err"}, ERR, 0);
    endtask

    task automatic run_reset();
        int c0;
        int first;
        int last;
        set_cfg(6, 0, 0, 2);
        do_start(1'b1, c0);
        first = c0 + SYNC_LEN + 2;
        sched(first, 6, 2, 0, 1'b1, 1 << 30, last);
        wait_neg(first + 7);
        #2;
        RST_N = 1'b0;
        expq.delete();
        #1;
        chk_reset_vals("async_rst");
        ASYNC_START = 1'b1;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (10) begin
            @(negedge CLK);
            chk("held_start_busy", BUSY, 0);
        end
        chk("held_start_done", DONE, 1);
        ASYNC_START = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    initial begin
        int dl;
        int nb;
        repeat (3) @(negedge CLK);
        chk_reset_vals("reset");
        RST_N = 1'b1;
        repeat (SYNC_LEN + 3) @(negedge CLK);
        chk_reset_vals("post_reset");

        run_valid(4, 0, 0, 1, 1'b0, 0, 0);
        run_valid(5, 0, 0, 1, 1'b0, 1, 2);
        run_valid(3, 4, 2, 3, 1'b0, 0, 0);
        run_err(4, 0);
        run_err(0, 3);
        run_valid(2, 1, 0, 2, 1'b0, 0, 0);
        run_abort();
        run_valid(3, 0, 1, 2, 1'b0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                dl = $urandom_range(0, 1) ? 0 : int'($urandom_range(1, 5));
                nb = (dl == 0) ? int'($urandom_range(0, 3)) : 0;
                run_err(dl, nb);
            end else begin
                run_valid(int'($urandom_range(1, 6)), int'($urandom_range(0, 5)),
                          int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
                          bit'($urandom_range(0, 1)), 0, 0);
            end
        end
        run_valid(1, 0, 0, 1, 1'b0, 0, 0);

        run_reset();
        run_valid(2, 0, 0, 1, 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
